// File: rtl/adrv9001_clk_out.sv
// adrv9001_clk_out
// Builds the parallel word that an external OSERDES turns into the forwarded
// DCLK for the ADRV9001 TX SSI. The clock starts and stops only on whole
// CLK_PATTERN words, so the device never sees a runt pulse. A frame strobe
// marks every FRAME_LEN-th word while running. Everything runs in clk_div.
module adrv9001_clk_out #(
    parameter int                    DATA_WIDTH    = 8,
    parameter logic [DATA_WIDTH-1:0] CLK_PATTERN   = 8'h55,
    parameter logic [DATA_WIDTH-1:0] IDLE_PATTERN  = 8'h00,
    parameter int                    SETTLE_CYCLES = 16,
    parameter int                    STOP_CYCLES   = 4,
    parameter int                    FRAME_LEN     = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_enable,
    output logic [DATA_WIDTH-1:0] o_clk_word,
    output logic                  o_frame_strobe,
    output logic                  o_running,
    output logic [1:0]            o_state,
    output logic [31:0]           o_run_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_SETTLE = 2'b01,
        S_RUN    = 2'b10,
        S_STOP   = 2'b11
    } state_t;

    // Terminal counts; comparing against PARAM-1 gives exactly PARAM cycles.
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] STOP_LAST   = 8'(STOP_CYCLES - 1);
    localparam logic [7:0] FRAME_LAST  = 8'(FRAME_LEN - 1);

    state_t                r_state;
    logic [7:0]            r_settle_cnt;
    logic [7:0]            r_stop_cnt;
    logic [7:0]            r_frame_cnt;
    logic [DATA_WIDTH-1:0] r_clk_word;
    logic                  r_frame_strobe;
    logic                  r_running;
    logic [31:0]           r_run_count;

    state_t                w_next_state;
    logic [7:0]            w_settle_nxt;
    logic [7:0]            w_stop_nxt;
    logic [7:0]            w_frame_nxt;
    logic                  w_clear_run;
    logic                  w_toggling;

    // Next-state and next-counter decode; outputs are registered from these.
    always_comb begin
        w_next_state = r_state;
        w_settle_nxt = r_settle_cnt;
        w_stop_nxt   = r_stop_cnt;
        w_frame_nxt  = r_frame_cnt;
        w_clear_run  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_enable) begin
                    w_next_state = S_SETTLE;
                    w_settle_nxt = 8'd0;
                    w_clear_run  = 1'b1;
                end
            end
            S_SETTLE: begin
                if (!i_enable) begin
                    w_next_state = S_IDLE;
                end else if (r_settle_cnt == SETTLE_LAST) begin
                    w_next_state = S_RUN;
                    w_frame_nxt  = 8'd0;
                end else begin
                    w_settle_nxt = r_settle_cnt + 8'd1;
                end
            end
            S_RUN: begin
                if (!i_enable) begin
                    w_next_state = S_STOP;
                    w_stop_nxt   = 8'd0;
                end else if (r_frame_cnt == FRAME_LAST) begin
                    w_frame_nxt  = 8'd0;
                end else begin
                    w_frame_nxt  = r_frame_cnt + 8'd1;
                end
            end
            S_STOP: begin
                // enable is deliberately ignored here so the burst always ends
                // on a whole number of words and IDLE is visited at least once.
                if (r_stop_cnt == STOP_LAST) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_stop_nxt   = r_stop_cnt + 8'd1;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign w_toggling = (w_next_state == S_RUN) || (w_next_state == S_STOP);

    // State, counters and registered outputs; reset overrides everything.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_settle_cnt   <= 8'd0;
            r_stop_cnt     <= 8'd0;
            r_frame_cnt    <= 8'd0;
            r_clk_word     <= IDLE_PATTERN;
            r_frame_strobe <= 1'b0;
            r_running      <= 1'b0;
            r_run_count    <= 32'd0;
        end else begin
            r_state        <= w_next_state;
            r_settle_cnt   <= w_settle_nxt;
            r_stop_cnt     <= w_stop_nxt;
            r_frame_cnt    <= w_frame_nxt;
            r_clk_word     <= w_toggling ? CLK_PATTERN : IDLE_PATTERN;
            r_running      <= w_toggling;
            r_frame_strobe <= (w_next_state == S_RUN) && (w_frame_nxt == 8'd0);
            if (w_clear_run) begin
                r_run_count <= 32'd0;
            end else if (w_next_state == S_RUN) begin
                r_run_count <= r_run_count + 32'd1;
            end
        end
    end

    assign o_clk_word     = r_clk_word;
    assign o_frame_strobe = r_frame_strobe;
    assign o_running      = r_running;
    assign o_state        = r_state;
    assign o_run_count    = r_run_count;

endmodule
